chip8_sequencer: RTL and testbench
==================================

# chip8_sequencer

Parametrised fetch/sequence controller for the Chip-8 core. Owns the program counter, call stack, instruction fetch from program memory and the beat counter for multicycle opcodes. Presents a latched opcode plus a per-beat execute strobe to the combinational `Chip8_CPU` datapath, which performs the register, ALU, timer and memory work. Adds PC-flow, skip, key-wait and stack-fault behaviour that the datapath does not provide.

## Interface
- `ADDR_W`, 12: program-memory address width; PC, stack entries and `nnn` arithmetic use this width.
- `STACK_DEPTH`, 16: call-stack entries (≥2).
- `PC_RESET`, 'h200: PC value after reset.
- `cpu_clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `run`  in  1  1 = start the next fetch; sampled only in FETCH0.
- `mem_addr`  out  ADDR_W  fetch address; synchronous RAM, data returns the following cycle.
- `mem_readdata`  in  8  fetch data byte.
- `reg_vx`, `reg_vy`, `reg_v0`  in  8 each  Vx, Vy and V0 for the held `instruction`; combinationally valid while `instruction` is stable.
- `keys`  in  16  pressed-key bitmap, bit k = key k.
- `instruction`  out  16  latched opcode to the datapath; reset 16'h0000.
- `exec_stb`  out  1  one-cycle pulse per execute beat; reset 0.
- `control`  out  4  beat index within a multicycle opcode; 0 for single-beat opcodes; reset 0.
- `key_code`  out  4  lowest-index pressed key, latched at the Fx0A wake-up; reset 0.
- `pc`  out  ADDR_W  current PC; reset `PC_RESET`.
- `fault`  out  1  sticky stack overflow/underflow; reset 0.

## Operation
- States:
  - FETCH0: drive `mem_addr` = pc.
  - FETCH1: drive `mem_addr` = pc+1; load `ir[15:8]`.
  - FETCH2: load `ir[7:0]`.
  - EXEC
  - MULTI
  - WAITKEY
  - HALT
- Transitions:
  - FETCH0 → FETCH1 when `run` = 1; otherwise stay in FETCH0.
  - FETCH1 → FETCH2 → EXEC unconditionally.
- EXEC: `exec_stb` = 1, `control` = 0. Then:
  - Fx55 / Fx65 with x > 0, or Fx33: → MULTI.
  - Fx0A: → WAITKEY.
  - Stack fault: → HALT.
  - Otherwise: update the PC and go to FETCH0.
- PC update rules, all modulo 2^ADDR_W:
  - Default: pc+2.
  - 3xkk / 4xkk / 5xy0 / 9xy0: pc+4 when the condition holds (Vx==kk, Vx!=kk, Vx==Vy, Vx!=Vy respectively).
  - Ex9E: pc+4 when `keys[Vx[3:0]]` = 1. ExA1: pc+4 when it is 0.
  - 1nnn: nnn.
  - 2nnn: push pc+2, then pc = nnn.
  - 00EE: pop.
  - Bnnn: nnn + zero-extended V0, truncated to ADDR_W.
- MULTI: one `exec_stb` per beat, `control` counts 1, 2, … up to the last beat.
  - Fx55 / Fx65: last beat is x; total beats = x+1.
  - Fx33: last beat is 2; total beats = 3.
  - After the last beat: pc+2, → FETCH0.
- WAITKEY: `exec_stb` = 0 while `keys` == 0.
  - When `keys` != 0: latch `key_code`, pulse `exec_stb` once, pc+2, → FETCH0.
  - `run` is ignored in this state.
- Stack faults:
  - Push while full: stack and PC unchanged, `fault` = 1, → HALT.
  - Pop while empty: stack and PC unchanged, `fault` = 1, → HALT.
  - `exec_stb` still pulses for that EXEC beat.
  - HALT is left only by `reset`.
- Unrecognised opcodes, and 00E0 / Dxyn, execute as single-beat instructions with PC = pc+2.

## Timing
- Single-beat instruction: 4 cycles from FETCH0 to the next FETCH0.
- Multi-beat instruction of N beats: 3+N cycles. Fx0A additionally takes its wait cycles.
- `instruction` changes only at the FETCH2 → EXEC edge and is stable through all execute beats.
- `pc` updates on the edge that leaves the final execute beat.
- `mem_readdata` is sampled exactly one cycle after the matching `mem_addr`.
- `reset` asserted in any state: on the next edge all outputs take their reset values, the stack pointer goes to 0 and the state goes to FETCH0.
- `run` deasserting mid-instruction does not stall it; the sequencer completes the instruction and then waits in FETCH0.
- Simultaneous `reset` and a fault: reset wins, so `fault` = 0.

## Structure
- `chip8_pkg`:
  - `seq_state_t` enum for the seven states.
  - Opcode-class constants: OP_RET = 16'h00EE, OP_CLS = 16'h00E0, F-group low bytes 8'h0A, 8'h33, 8'h55, 8'h65, E-group low bytes 8'h9E, 8'hA1.
- Sub-module `chip8_stack`:
  - Parametrised LIFO, `STACK_DEPTH` × `ADDR_W`.
  - Push/pop inputs; top, full and empty outputs.
  - Stack pointer width is $clog2(STACK_DEPTH+1).
  - Synchronous reset to empty.

## Test plan
- Reset, then memory bytes 0x200 = 8'h12, 0x201 = 8'h34 with `run` = 1 → `mem_addr` 0x200, 0x201; `instruction` = 16'h1234 on cycle 4; `exec_stb` pulses once; `pc` = 0x234.
- Opcode 16'h3A05 with `reg_vx` = 5 → `pc` advances by 4. Repeat with `reg_vx` = 6 → `pc` advances by 2.
- Opcode 16'h2400 at pc 0x300, then 16'h00EE at 0x400 → `pc` goes 0x400, then 0x302.
- Seventeen consecutive 2nnn calls with `STACK_DEPTH` = 16 → 17th call sets `fault` = 1, `pc` holds, state stays in HALT until `reset`. 00EE straight after reset also sets `fault`.
- Opcode 16'hF355 → four `exec_stb` pulses with `control` = 0, 1, 2, 3; 7 cycles total; `pc` advances by 2. Opcode 16'hF033 → `control` = 0, 1, 2.
- Opcode 16'hF20A with `keys` = 0 for 5 cycles, then 16'h0140 → no strobe while waiting; one strobe follows with `key_code` = 6. Asserting `reset` while waiting → FETCH0, `pc` = `PC_RESET`.

Source files
------------

// File: rtl/chip8_pkg.sv
// Shared types and opcode constants for the Chip-8 fetch/sequence controller.
package chip8_pkg;

  typedef enum logic [2:0] {
    S_FETCH0,
    S_FETCH1,
    S_FETCH2,
    S_EXEC,
    S_MULTI,
    S_WAITKEY,
    S_HALT
  } seq_state_t;

  localparam logic [15:0] OP_RET = 16'h00EE;
  localparam logic [15:0] OP_CLS = 16'h00E0;

  localparam logic [7:0] F_WAITKEY = 8'h0A;
  localparam logic [7:0] F_BCD     = 8'h33;
  localparam logic [7:0] F_STORE   = 8'h55;
  localparam logic [7:0] F_LOAD    = 8'h65;
  localparam logic [7:0] E_SKP     = 8'h9E;
  localparam logic [7:0] E_SKNP    = 8'hA1;

  // Index of the lowest set bit; 0 when none is set.
  function automatic logic [3:0] lowest_key(input logic [15:0] k);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (k[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/chip8_stack.sv
// Return-address LIFO; push/pop requests that would overflow/underflow are ignored.
module chip8_stack
  import chip8_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned STACK_DEPTH = 16
) (
  input  logic              cpu_clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              full,
  output logic              empty
);

  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(STACK_DEPTH);

  logic [ADDR_W-1:0] entries [STACK_DEPTH];
  logic [SP_W-1:0]   sp;

  assign full  = (sp == SP_W'(STACK_DEPTH));
  assign empty = (sp == '0);
  assign top   = entries[IDX_W'(sp - SP_W'(1))];

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SP_W'(1);
    end else if (pop && !empty) begin
      sp <= sp - SP_W'(1);
    end
  end

  // Storage needs no reset; only entries below sp are ever read meaningfully.
  always_ff @(posedge cpu_clk) begin
    if (!reset && push && !full) begin
      entries[IDX_W'(sp)] <= push_data;
    end
  end

endmodule

// File: rtl/chip8_sequencer.sv
// Chip-8 fetch/sequence controller: PC, call stack, opcode fetch and execute-beat strobes.
module chip8_sequencer
  import chip8_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned STACK_DEPTH = 16,
  parameter int unsigned PC_RESET    = 'h200
) (
  input  logic              cpu_clk,
  input  logic              reset,
  input  logic              run,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_readdata,
  input  logic [7:0]        reg_vx,
  input  logic [7:0]        reg_vy,
  input  logic [7:0]        reg_v0,
  input  logic [15:0]       keys,
  output logic [15:0]       instruction,
  output logic              exec_stb,
  output logic [3:0]        control,
  output logic [3:0]        key_code,
  output logic [ADDR_W-1:0] pc,
  output logic              fault
);

  seq_state_t        state, state_n;
  logic [7:0]        ir_hi, ir_hi_n;
  logic [ADDR_W-1:0] pc_n, mem_addr_n;
  logic [15:0]       instr_n;
  logic              stb_n, fault_n;
  logic [3:0]        ctrl_n, key_code_n;

  logic              push, pop, stk_full, stk_empty;
  logic [ADDR_W-1:0] stk_top;

  logic [3:0]        op, x;
  logic [7:0]        kk;
  logic [ADDR_W-1:0] nnn, pc_plus2, pc_plus4, flow_pc;
  logic              is_call, is_ret, is_multi, is_waitkey;
  logic [3:0]        last_beat;

  assign op       = instruction[15:12];
  assign x        = instruction[11:8];
  assign kk       = instruction[7:0];
  assign nnn      = ADDR_W'(instruction[11:0]);
  assign pc_plus2 = pc + ADDR_W'(2);
  assign pc_plus4 = pc + ADDR_W'(4);

  assign is_call    = (op == 4'h2);
  assign is_ret     = (instruction == OP_RET);
  assign is_waitkey = (op == 4'hF) && (kk == F_WAITKEY);
  assign is_multi   = (op == 4'hF) &&
                      (((kk == F_STORE || kk == F_LOAD) && x != 4'd0) || kk == F_BCD);
  assign last_beat  = (kk == F_BCD) ? 4'd2 : x;

  chip8_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .cpu_clk   (cpu_clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_plus2),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  // Next PC for single-beat opcodes that complete in EXEC.
  always_comb begin
    flow_pc = pc_plus2;
    case (op)
      4'h0: begin
        if (is_ret)                     flow_pc = stk_top;
        else if (instruction == OP_CLS) flow_pc = pc_plus2;
      end
      4'h1: flow_pc = nnn;
      4'h2: flow_pc = nnn;
      4'h3: if (reg_vx == kk) flow_pc = pc_plus4;
      4'h4: if (reg_vx != kk) flow_pc = pc_plus4;
      4'h5: if (instruction[3:0] == 4'h0 && reg_vx == reg_vy) flow_pc = pc_plus4;
      4'h9: if (instruction[3:0] == 4'h0 && reg_vx != reg_vy) flow_pc = pc_plus4;
      4'hB: flow_pc = nnn + ADDR_W'(reg_v0);
      4'hE: begin
        if (kk == E_SKP && keys[reg_vx[3:0]])        flow_pc = pc_plus4;
        else if (kk == E_SKNP && !keys[reg_vx[3:0]]) flow_pc = pc_plus4;
      end
      default: flow_pc = pc_plus2;
    endcase
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    ir_hi_n    = ir_hi;
    instr_n    = instruction;
    stb_n      = 1'b0;
    ctrl_n     = 4'd0;
    key_code_n = key_code;
    fault_n    = fault;
    push       = 1'b0;
    pop        = 1'b0;
    mem_addr_n = mem_addr;

    unique case (state)
      S_FETCH0: if (run) state_n = S_FETCH1;
      S_FETCH1: begin
        ir_hi_n = mem_readdata;
        state_n = S_FETCH2;
      end
      S_FETCH2: begin
        instr_n = {ir_hi, mem_readdata};
        stb_n   = 1'b1;
        state_n = S_EXEC;
      end
      S_EXEC: begin
        if (is_multi) begin
          stb_n   = 1'b1;
          ctrl_n  = 4'd1;
          state_n = S_MULTI;
        end else if (is_waitkey) begin
          state_n = S_WAITKEY;
        end else if ((is_call && stk_full) || (is_ret && stk_empty)) begin
          fault_n = 1'b1;
          state_n = S_HALT;
        end else begin
          push    = is_call;
          pop     = is_ret;
          pc_n    = flow_pc;
          state_n = S_FETCH0;
        end
      end
      S_MULTI: begin
        if (control == last_beat) begin
          pc_n    = pc_plus2;
          state_n = S_FETCH0;
        end else begin
          stb_n  = 1'b1;
          ctrl_n = control + 4'd1;
        end
      end
      S_WAITKEY: begin
        if (keys != 16'h0000) begin
          key_code_n = lowest_key(keys);
          stb_n      = 1'b1;
          pc_n       = pc_plus2;
          state_n    = S_FETCH0;
        end
      end
      S_HALT: state_n = S_HALT;
      default: state_n = S_FETCH0;
    endcase

    // Fetch address tracks the state being entered.
    if (state_n == S_FETCH0)      mem_addr_n = pc_n;
    else if (state_n == S_FETCH1) mem_addr_n = pc + ADDR_W'(1);
  end

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state       <= S_FETCH0;
      pc          <= ADDR_W'(PC_RESET);
      mem_addr    <= ADDR_W'(PC_RESET);
      ir_hi       <= 8'h00;
      instruction <= 16'h0000;
      exec_stb    <= 1'b0;
      control     <= 4'd0;
      key_code    <= 4'd0;
      fault       <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      mem_addr    <= mem_addr_n;
      ir_hi       <= ir_hi_n;
      instruction <= instr_n;
      exec_stb    <= stb_n;
      control     <= ctrl_n;
      key_code    <= key_code_n;
      fault       <= fault_n;
    end
  end

endmodule

// File: tb/tb_chip8_sequencer.sv
// Directed bench for chip8_sequencer with a synchronous program-memory model.
module tb_chip8_sequencer;

  logic        cpu_clk;
  logic        reset;
  logic        run;
  logic [11:0] mem_addr;
  logic [7:0]  mem_readdata;
  logic [7:0]  reg_vx, reg_vy, reg_v0;
  logic [15:0] keys;
  logic [15:0] instruction;
  logic        exec_stb;
  logic [3:0]  control;
  logic [3:0]  key_code;
  logic [11:0] pc;
  logic        fault;

  logic [7:0]  mem [4096];
  logic [11:0] exp_pc;
  int          n_tests;
  int          n_fail;

  typedef struct {
    logic [15:0] op;
    logic [7:0]  vx;
    logic [7:0]  vy;
    logic [7:0]  v0;
    logic [15:0] keys;
    logic [11:0] npc;
    int          stb;
    logic [15:0] ctrl;
    int          cyc;
  } vec_t;

  vec_t vecs [18];

  chip8_sequencer #(
    .ADDR_W      (12),
    .STACK_DEPTH (16),
    .PC_RESET    ('h200)
  ) dut (
    .cpu_clk      (cpu_clk),
    .reset        (reset),
    .run          (run),
    .mem_addr     (mem_addr),
    .mem_readdata (mem_readdata),
    .reg_vx       (reg_vx),
    .reg_vy       (reg_vy),
    .reg_v0       (reg_v0),
    .keys         (keys),
    .instruction  (instruction),
    .exec_stb     (exec_stb),
    .control      (control),
    .key_code     (key_code),
    .pc           (pc),
    .fault        (fault)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  always @(posedge cpu_clk) mem_readdata <= mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    @(negedge cpu_clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run   = 1'b0;
    tick();
    tick();
    reset  = 1'b0;
    exp_pc = 12'h200;
  endtask

  // Places op at exp_pc, pulses run for one cycle, then observes n_ticks cycles.
  task automatic exec_op(input logic [15:0] op, input int n_ticks,
                         output int pc_tick, output int n_stb, output logic [15:0] ctrl_log);
    logic [11:0] start_pc;
    start_pc = exp_pc;
    mem[start_pc]         = op[15:8];
    mem[start_pc + 12'd1] = op[7:0];
    pc_tick  = -1;
    n_stb    = 0;
    ctrl_log = 16'h0000;
    run      = 1'b1;
    for (int t = 1; t <= n_ticks; t++) begin
      tick();
      run = 1'b0;
      if (exec_stb) begin
        n_stb++;
        ctrl_log = {ctrl_log[11:0], control};
        check("instr_stable", 32'(instruction), 32'(op));
      end
      if (pc_tick < 0 && pc != start_pc) pc_tick = t;
    end
  endtask

  initial begin
    int          pc_tick, n_stb, stb_wait;
    logic [15:0] ctrl_log;
    logic [11:0] tgt;

    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    run     = 1'b0;
    reg_vx  = 8'h00;
    reg_vy  = 8'h00;
    reg_v0  = 8'h00;
    keys    = 16'h0000;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

    vecs[0]  = '{16'h3A05, 8'h05, 8'h00, 8'h00, 16'h0000, 12'h238, 1, 16'h0000, 4};
    vecs[1]  = '{16'h3A05, 8'h06, 8'h00, 8'h00, 16'h0000, 12'h23A, 1, 16'h0000, 4};
    vecs[2]  = '{16'h4A05, 8'h06, 8'h00, 8'h00, 16'h0000, 12'h23E, 1, 16'h0000, 4};
    vecs[3]  = '{16'h5AB0, 8'h07, 8'h07, 8'h00, 16'h0000, 12'h242, 1, 16'h0000, 4};
    vecs[4]  = '{16'h9AB0, 8'h07, 8'h07, 8'h00, 16'h0000, 12'h244, 1, 16'h0000, 4};
    vecs[5]  = '{16'hE19E, 8'h03, 8'h00, 8'h00, 16'h0008, 12'h248, 1, 16'h0000, 4};
    vecs[6]  = '{16'hE1A1, 8'h03, 8'h00, 8'h00, 16'h0008, 12'h24A, 1, 16'h0000, 4};
    vecs[7]  = '{16'h00E0, 8'h00, 8'h00, 8'h00, 16'h0000, 12'h24C, 1, 16'h0000, 4};
    vecs[8]  = '{16'hB300, 8'h00, 8'h00, 8'h10, 16'h0000, 12'h310, 1, 16'h0000, 4};
    vecs[9]  = '{16'h1300, 8'h00, 8'h00, 8'h00, 16'h0000, 12'h300, 1, 16'h0000, 4};
    vecs[10] = '{16'h2400, 8'h00, 8'h00, 8'h00, 16'h0000, 12'h400, 1, 16'h0000, 4};
    vecs[11] = '{16'h00EE, 8'h00, 8'h00, 8'h00, 16'h0000, 12'h302, 1, 16'h0000, 4};
    vecs[12] = '{16'hF355, 8'h00, 8'h00, 8'h00, 16'h0000, 12'h304, 4, 16'h0123, 7};
    vecs[13] = '{16'hF033, 8'h00, 8'h00, 8'h00, 16'h0000, 12'h306, 3, 16'h0012, 6};
    vecs[14] = '{16'hF055, 8'h00, 8'h00, 8'h00, 16'h0000, 12'h308, 1, 16'h0000, 4};
    vecs[15] = '{16'hBFFF, 8'h00, 8'h00, 8'hFF, 16'h0000, 12'h0FE, 1, 16'h0000, 4};
    vecs[16] = '{16'h1FFE, 8'h00, 8'h00, 8'h00, 16'h0000, 12'hFFE, 1, 16'h0000, 4};
    vecs[17] = '{16'h0000, 8'h00, 8'h00, 8'h00, 16'h0000, 12'h000, 1, 16'h0000, 4};

    // Reset values
    do_reset();
    check("rst_pc",       32'(pc),          32'h200);
    check("rst_mem_addr", 32'(mem_addr),    32'h200);
    check("rst_instr",    32'(instruction), 32'h0);
    check("rst_stb",      32'(exec_stb),    32'h0);
    check("rst_control",  32'(control),     32'h0);
    check("rst_key_code", 32'(key_code),    32'h0);
    check("rst_fault",    32'(fault),       32'h0);

    // First fetch with cycle-level address and latency checks
    mem[12'h200] = 8'h12;
    mem[12'h201] = 8'h34;
    run = 1'b1;
    tick();
    run = 1'b0;
    check("f1_mem_addr", 32'(mem_addr), 32'h201);
    tick();
    check("f2_stb", 32'(exec_stb), 32'h0);
    tick();
    check("ex_instr",   32'(instruction), 32'h1234);
    check("ex_stb",     32'(exec_stb),    32'h1);
    check("ex_control", 32'(control),     32'h0);
    tick();
    check("jp_stb",      32'(exec_stb), 32'h0);
    check("jp_pc",       32'(pc),       32'h234);
    check("jp_mem_addr", 32'(mem_addr), 32'h234);
    exp_pc = 12'h234;

    // Directed opcode table
    for (int v = 0; v < 18; v++) begin
      reg_vx = vecs[v].vx;
      reg_vy = vecs[v].vy;
      reg_v0 = vecs[v].v0;
      keys   = vecs[v].keys;
      exec_op(vecs[v].op, 10, pc_tick, n_stb, ctrl_log);
      check($sformatf("v%0d_pc", v),     32'(pc),       32'(vecs[v].npc));
      check($sformatf("v%0d_stb", v),    32'(n_stb),    32'(vecs[v].stb));
      check($sformatf("v%0d_ctrl", v),   32'(ctrl_log), 32'(vecs[v].ctrl));
      check($sformatf("v%0d_cycles", v), 32'(pc_tick),  32'(vecs[v].cyc));
      exp_pc = vecs[v].npc;
    end
    reg_vx = 8'h00;
    reg_vy = 8'h00;
    reg_v0 = 8'h00;
    keys   = 16'h0000;

    // Fx0A: EXEC beat, silent wait, then one wake strobe with lowest key
    exec_op(16'hF20A, 3, pc_tick, n_stb, ctrl_log);
    check("wk_exec_stb", 32'(n_stb), 32'h1);
    stb_wait = 0;
    for (int t = 0; t < 5; t++) begin
      tick();
      if (exec_stb) stb_wait++;
    end
    check("wk_no_stb", 32'(stb_wait), 32'h0);
    check("wk_pc_hold", 32'(pc), 32'h000);
    keys = 16'h0140;
    tick();
    keys = 16'h0000;
    check("wk_stb",      32'(exec_stb), 32'h1);
    check("wk_key_code", 32'(key_code), 32'h6);
    check("wk_pc",       32'(pc),       32'h002);
    tick();
    check("wk_stb_once", 32'(exec_stb), 32'h0);
    exp_pc = 12'h002;

    // Reset while waiting for a key
    exec_op(16'hF10A, 6, pc_tick, n_stb, ctrl_log);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("wkrst_pc",       32'(pc),          32'h200);
    check("wkrst_mem_addr", 32'(mem_addr),    32'h200);
    check("wkrst_key_code", 32'(key_code),    32'h0);
    check("wkrst_instr",    32'(instruction), 32'h0);
    exp_pc = 12'h200;

    // Fill the stack; the 17th call overflows
    for (int i = 0; i < 17; i++) begin
      tgt = exp_pc + 12'h010;
      exec_op({4'h2, tgt}, 6, pc_tick, n_stb, ctrl_log);
      if (i < 16) begin
        exp_pc = tgt;
        check($sformatf("call%0d_pc", i),    32'(pc),    32'(exp_pc));
        check($sformatf("call%0d_fault", i), 32'(fault), 32'h0);
      end else begin
        check("ovf_pc",    32'(pc),    32'h300);
        check("ovf_fault", 32'(fault), 32'h1);
        check("ovf_stb",   32'(n_stb), 32'h1);
      end
    end
    run = 1'b1;
    stb_wait = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (exec_stb) stb_wait++;
    end
    run = 1'b0;
    check("halt_no_stb", 32'(stb_wait), 32'h0);
    check("halt_pc",     32'(pc),       32'h300);
    check("halt_fault",  32'(fault),    32'h1);

    // Reset clears the fault; a return on an empty stack faults
    do_reset();
    check("rst2_fault", 32'(fault), 32'h0);
    exec_op(16'h00EE, 6, pc_tick, n_stb, ctrl_log);
    check("unf_fault", 32'(fault), 32'h1);
    check("unf_pc",    32'(pc),    32'h200);
    check("unf_stb",   32'(n_stb), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
